uart_tx_frame: RTL

- UART transmit-side framer. Takes a parallel byte and serialises it onto TX_OUT as start bit, LSB-first data, optional parity and one stop bit, at one bit per CLK cycle.
- CLK is the TX bit clock, already divided to the baud rate upstream by the clock divider. This is the counterpart of the RX path: the RX sampler takes three oversampled votes per bit and this block emits one level per bit.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_parity_calc.sv | 27 ++
 rtl/uart_tx_frame.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and line-level constants for the TX framer
//                and its parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmit framer states, in the order they appear on the line.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Line levels for the framing bits.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Parity type selector encoding.
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_parity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : uart_parity_calc
//  Description : Combinational parity generator. Even parity is the XOR of
//                the data bits; odd parity is its complement.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity_bit
);

    logic w_xor;

    // Reduce the data word, then invert for odd parity.
    always_comb begin
        w_xor      = ^data;
        parity_bit = (par_typ == PAR_ODD) ? ~w_xor : w_xor;
    end

endmodule : uart_parity_calc
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame
//  Description : UART transmit framer. Serialises a parallel word as start
//                bit, LSB-first data, optional parity and one stop bit, one
//                bit per CLK (CLK is already the baud-rate bit clock).
//                TX_OUT and busy come straight from flops; their next values
//                are decoded from the next state so the line changes on the
//                same edge the FSM moves.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    // A one-bit word still needs a one-bit counter.
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    tx_state_e             r_state;
    tx_state_e             w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_parity;
    logic                  r_par_en;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_tx_nxt;
    logic                  w_busy_nxt;
    logic                  w_parity;
    logic                  w_accept;

    // Parity is worked out from the incoming word on the accept edge and
    // stored, so later changes on P_DATA/PAR_TYP cannot disturb the frame.
    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data       (P_DATA),
        .par_typ    (PAR_TYP),
        .parity_bit (w_parity)
    );

    assign w_accept  = (r_state == IDLE) && DATA_VALID;
    assign w_cnt_inc = r_cnt + C_CNT_ONE;

    // Next-state, next-counter and next-line-level decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = STOP_BIT;
        w_busy_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (DATA_VALID) begin
                    w_state_nxt = START;
                    w_tx_nxt    = START_BIT;
                    w_busy_nxt  = 1'b1;
                end
            end
            START: begin
                w_state_nxt = DATA;
                w_cnt_nxt   = '0;
                w_tx_nxt    = r_data[0];
                w_busy_nxt  = 1'b1;
            end
            DATA: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_par_en) begin
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_parity;
                    end else begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = STOP_BIT;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_tx_nxt  = r_data[w_cnt_inc];
                end
            end
            PARITY: begin
                w_state_nxt = STOP;
                w_tx_nxt    = STOP_BIT;
                w_busy_nxt  = 1'b1;
            end
            STOP: begin
                // Line stays high into IDLE; busy drops with the move.
                w_state_nxt = IDLE;
                w_tx_nxt    = STOP_BIT;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts any frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            TX_OUT  <= STOP_BIT;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            TX_OUT  <= w_tx_nxt;
            busy    <= w_busy_nxt;
        end
    end

    // Frame payload: captured once at accept and held for the whole frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_data   <= '0;
            r_parity <= 1'b0;
            r_par_en <= 1'b0;
        end else if (w_accept) begin
            r_data   <= P_DATA;
            r_parity <= w_parity;
            r_par_en <= PAR_EN;
        end
    end

endmodule : uart_tx_frame
`default_nettype wire
